// File: rtl/rr_arbiter8_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RECOVER = 2'd2
  } arb_state_t;

endpackage

// File: rtl/onehot_dec3.sv
// 3-to-8 one-hot decoder used to form the registered grant vector.
module onehot_dec3
  import rr_arbiter8_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  assign onehot = N_REQ'(1) << idx;

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with hold limit and break-before-make gap.
// The owner's give-up input is named rel because release is a reserved word.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             rel,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  if (HOLD_MAX < 1 || HOLD_MAX > 15 || (2 ** CNT_W) <= HOLD_MAX) begin : g_bad_param
    $error("rr_arbiter8: HOLD_MAX must be 1..15 and fit in CNT_W bits");
  end

  arb_state_t       state, state_d;
  logic [IDX_W-1:0] ptr, ptr_d;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_d;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] idx_d;
  logic             vld_d;
  logic [N_REQ-1:0] dec_onehot;
  logic [N_REQ-1:0] grant_d;
  logic             exit_grant;

  // Scan downward so the lowest offset from ptr wins.
  always_comb begin
    sel_idx = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[ptr + IDX_W'(i)]) sel_idx = ptr + IDX_W'(i);
    end
  end

  assign exit_grant = rel | ~req[grant_idx] | (hold_cnt == CNT_W'(HOLD_MAX - 1));

  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    hold_cnt_d = hold_cnt;
    idx_d      = grant_idx;
    vld_d      = grant_valid;
    case (state)
      IDLE, RECOVER: begin
        hold_cnt_d = '0;
        if (|req) begin
          state_d = GRANT;
          idx_d   = sel_idx;
          vld_d   = 1'b1;
        end else begin
          state_d = IDLE;
          idx_d   = '0;
          vld_d   = 1'b0;
        end
      end
      GRANT: begin
        if (exit_grant) begin
          state_d    = RECOVER;
          idx_d      = '0;
          vld_d      = 1'b0;
          ptr_d      = grant_idx + IDX_W'(1);
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        idx_d      = '0;
        vld_d      = 1'b0;
        hold_cnt_d = '0;
      end
    endcase
  end

  onehot_dec3 u_dec (
    .idx    (idx_d),
    .onehot (dec_onehot)
  );

  assign grant_d = vld_d ? dec_onehot : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      hold_cnt    <= hold_cnt_d;
      grant       <= grant_d;
      grant_idx   <= idx_d;
      grant_valid <= vld_d;
    end
  end

endmodule
